// File: rtl/avalon_multi_interval_timer_pkg.sv
// rtl/avalon_multi_interval_timer_pkg.sv - register map constants for the multi-channel interval timer
package avalon_timer_pkg;

    localparam int ADDR_OFS_W = 3;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

endpackage

// File: rtl/avalon_multi_interval_timer_if.sv
// rtl/avalon_multi_interval_timer_if.sv - 16-bit Avalon-MM slave bus bundle
interface avalon_multi_interval_timer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/interval_timer_channel.sv
// rtl/interval_timer_channel.sv - one programmable interval timer: counter, period, snapshot, status/control
module interval_timer_channel
    import avalon_timer_pkg::*;
#(
    parameter int          COUNT_W        = 17,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h1869F,
    parameter bit          ALWAYS_RUN     = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  wr_strb,
    input  logic [15:0] writedata,
    input  logic [2:0]  rd_ofs,
    output logic [15:0] rdata,
    output logic        irq
);

    logic [COUNT_W-1:0] counter;
    logic [COUNT_W-1:0] period;
    logic [COUNT_W-1:0] snap;
    logic [COUNT_W-1:0] period_nxt;
    logic               run;
    logic               to;
    logic               ito;
    logic               cont;
    logic               tev;
    logic               period_we;
    logic               run_cmd;

    // Splits a COUNT_W field into its low/high 16-bit bus words; bits beyond COUNT_W read 0.
    function automatic logic [15:0] field_word(input logic [COUNT_W-1:0] v, input logic hi);
        logic [15:0] w;
        w = '0;
        for (int b = 0; b < COUNT_W; b++) begin
            if (hi ? (b >= 16) : (b < 16)) w[b % 16] = v[b];
        end
        return w;
    endfunction

    assign tev       = run && (counter == '0);
    assign period_we = wr_strb[REG_PERIODL] | wr_strb[REG_PERIODH];
    assign run_cmd   = wr_strb[REG_CONTROL] && !ALWAYS_RUN
                       && (writedata[CTRL_STOP] || writedata[CTRL_START]);
    assign irq       = to & ito;

    always_comb begin
        period_nxt = period;
        for (int b = 0; b < COUNT_W; b++) begin
            if (b < 16) begin
                if (wr_strb[REG_PERIODL]) period_nxt[b] = writedata[b];
            end else if (wr_strb[REG_PERIODH]) begin
                period_nxt[b] = writedata[b - 16];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= COUNT_W'(DEFAULT_PERIOD);
            period  <= COUNT_W'(DEFAULT_PERIOD);
            snap    <= COUNT_W'(DEFAULT_PERIOD);
            run     <= ALWAYS_RUN;
            to      <= 1'b0;
            ito     <= 1'b0;
            cont    <= ALWAYS_RUN;
        end else begin
            if (period_we) begin
                period  <= period_nxt;
                counter <= period_nxt;
            end else if (run) begin
                counter <= tev ? period : counter - COUNT_W'(1);
            end

            // Explicit bus commands take precedence over the one-shot auto-stop.
            if (period_we) begin
                if (!ALWAYS_RUN) run <= 1'b0;
            end else if (run_cmd) begin
                run <= !writedata[CTRL_STOP];
            end else if (tev && !cont) begin
                run <= 1'b0;
            end

            if (tev) to <= 1'b1;
            else if (wr_strb[REG_STATUS]) to <= 1'b0;

            if (wr_strb[REG_CONTROL]) begin
                ito  <= writedata[CTRL_ITO];
                cont <= ALWAYS_RUN | writedata[CTRL_CONT];
            end

            if (wr_strb[REG_SNAPL] | wr_strb[REG_SNAPH]) snap <= counter;
        end
    end

    always_comb begin
        rdata = '0;
        case (rd_ofs)
            REG_STATUS:  begin rdata[STAT_TO] = to;  rdata[STAT_RUN]  = run;  end
            REG_CONTROL: begin rdata[CTRL_ITO] = ito; rdata[CTRL_CONT] = cont; end
            REG_PERIODL: rdata = field_word(period, 1'b0);
            REG_PERIODH: rdata = field_word(period, 1'b1);
            REG_SNAPL:   rdata = field_word(snap, 1'b0);
            REG_SNAPH:   rdata = field_word(snap, 1'b1);
            default:     rdata = '0;
        endcase
    end

endmodule

// File: rtl/avalon_multi_interval_timer.sv
// rtl/avalon_multi_interval_timer.sv - NUM_CH interval timers behind one 16-bit Avalon-MM slave
module avalon_multi_interval_timer
    import avalon_timer_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          COUNT_W        = 17,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h1869F,
    parameter bit          ALWAYS_RUN     = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    avalon_multi_interval_timer_if.slave bus,
    output logic [NUM_CH-1:0]          irq
);

    localparam int ADDR_W = ADDR_OFS_W + $clog2(NUM_CH);

    logic [ADDR_W-1:0] ch_sel;
    logic [2:0]        ofs;
    logic              wr_cycle;
    logic [15:0]       ch_rdata [NUM_CH];
    logic [15:0]       rd_mux;

    assign ch_sel   = bus.address >> ADDR_OFS_W;
    assign ofs      = bus.address[ADDR_OFS_W-1:0];
    assign wr_cycle = bus.chipselect & ~bus.write_n;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [7:0] wr_strb;

        assign wr_strb = (wr_cycle && ch_sel == ADDR_W'(c)) ? (8'b1 << ofs) : 8'b0;

        interval_timer_channel #(
            .COUNT_W        (COUNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD),
            .ALWAYS_RUN     (ALWAYS_RUN)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_strb   (wr_strb),
            .writedata (bus.writedata),
            .rd_ofs    (ofs),
            .rdata     (ch_rdata[c]),
            .irq       (irq[c])
        );
    end

    // Channel indices with no channel behind them fall through to 0.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == ADDR_W'(c)) rd_mux = ch_rdata[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end

endmodule

// File: tb/tb_avalon_multi_interval_timer.sv
// tb/tb_avalon_multi_interval_timer.sv - randomized and directed bench with a behavioural timer model
module tb_avalon_multi_interval_timer;
    localparam int          NCH   = 4;
    localparam int          CW    = 17;
    localparam int unsigned DEF   = 32'h1869F;
    localparam int unsigned CMASK = (32'd1 << CW) - 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [NCH-1:0] irq;
    int             total = 0;
    int             bad = 0;
    bit             chk_en = 1'b0;

    avalon_multi_interval_timer_if #(.ADDR_W(5)) bus ();

    avalon_multi_interval_timer #(
        .NUM_CH(NCH), .COUNT_W(CW), .DEFAULT_PERIOD(DEF), .ALWAYS_RUN(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq)
    );

    always #5 clk = ~clk;

    // Timer state as plain numbers; each channel is an independent down-counter.
    int unsigned m_cnt [NCH];
    int unsigned m_per [NCH];
    int unsigned m_snap[NCH];
    bit          m_run [NCH];
    bit          m_to  [NCH];
    bit          m_ito [NCH];
    bit          m_cont[NCH];
    logic [15:0] m_rd;

    function automatic logic [15:0] m_read(input int a);
        int ch, o;
        ch = a / 8;
        o  = a % 8;
        if (ch >= NCH) return 16'h0;
        case (o)
            0: return {14'b0, m_run[ch], m_to[ch]};
            1: return {14'b0, m_cont[ch], m_ito[ch]};
            2: return 16'(m_per[ch]);
            3: return 16'(m_per[ch] >> 16);
            4: return 16'(m_snap[ch]);
            5: return 16'(m_snap[ch] >> 16);
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [NCH-1:0] m_irq();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_to[c] & m_ito[c];
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int a, o;
        int unsigned d, nc;
        bit hit, tev, nr;
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = DEF; m_per[c] = DEF; m_snap[c] = DEF;
                m_run[c] = 0; m_to[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
            end
            m_rd = 16'h0;
        end else begin
            a    = int'(bus.address);
            o    = a % 8;
            d    = bus.writedata;
            m_rd = m_read(a);
            for (int c = 0; c < NCH; c++) begin
                hit = bus.chipselect && !bus.write_n && (a / 8 == c);
                tev = m_run[c] && m_cnt[c] == 0;
                nc  = m_cnt[c];
                nr  = m_run[c];
                if (m_run[c]) begin
                    if (tev) begin
                        nc = m_per[c];
                        if (!m_cont[c]) nr = 0;
                    end else begin
                        nc = m_cnt[c] - 1;
                    end
                end
                if (tev) m_to[c] = 1;
                else if (hit && o == 0) m_to[c] = 0;
                if (hit) begin
                    case (o)
                        1: begin
                            m_ito[c] = d[0]; m_cont[c] = d[1];
                            if (d[3]) nr = 0; else if (d[2]) nr = 1;
                        end
                        2: begin m_per[c] = (m_per[c] & 32'hFFFF0000) | d; nc = m_per[c]; nr = 0; end
                        3: begin m_per[c] = ((d << 16) | (m_per[c] & 32'hFFFF)) & CMASK; nc = m_per[c]; nr = 0; end
                        4, 5: m_snap[c] = m_cnt[c];
                        default: ;
                    endcase
                end
                m_cnt[c] = nc;
                m_run[c] = nr;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("irq", 32'(irq), 32'(m_irq()));
            chk("readdata", 32'(bus.readdata), 32'(m_rd));
        end
    end

    task automatic bus_write(input int ch, input int o, input logic [15:0] d);
        bus.address    = 5'(ch * 8 + o);
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input int ch, input int o, output logic [15:0] d);
        bus.address    = 5'(ch * 8 + o);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(posedge clk); #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        int n;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        // reset values
        bus_read(0, 0, rd); chk("t1_status", 32'(rd), 32'h0000);
        bus_read(0, 2, rd); chk("t1_periodl", 32'(rd), 32'h869F);
        bus_read(0, 3, rd); chk("t1_periodh", 32'(rd), 32'h0001);
        n = 0;
        repeat (200) begin @(posedge clk); #1; if (irq != 0) n++; end
        chk("t1_irq_quiet", 32'(n), 32'd0);

        // continuous, period 9 -> 10 clks per timeout
        bus_write(1, 2, 16'd9);
        bus_write(1, 3, 16'd0);
        bus_write(1, 1, 16'h7);
        n = 0;
        while (!irq[1] && n < 100) begin @(posedge clk); #1; n++; end
        chk("t2_first_rise", 32'(n), 32'd10);
        chk("t2_other_irq", 32'({irq[3:2], irq[0]}), 32'd0);
        repeat (2) begin
            bus_write(1, 0, 16'h0);
            n = 1;
            while (!irq[1] && n < 100) begin @(posedge clk); #1; n++; end
            chk("t2_period", 32'(n), 32'd10);
        end

        // one-shot
        bus_write(2, 2, 16'd4);
        bus_write(2, 3, 16'd0);
        bus_write(2, 1, 16'h5);
        repeat (20) @(posedge clk);
        #1;
        bus_read(2, 0, rd); chk("t3_status", 32'(rd), 32'h0001);
        bus_write(2, 4, 16'h0);
        bus_read(2, 4, rd); chk("t3_counter_hold", 32'(rd), 32'd4);

        // snapshot while running
        bus_write(3, 2, 16'd1000);
        bus_write(3, 3, 16'd0);
        bus_write(3, 1, 16'h4);
        repeat (100) @(posedge clk);
        #1;
        bus_write(3, 4, 16'h0);
        bus_read(3, 4, rd); chk("t4_snapl", 32'(rd), 32'd900);
        bus_read(3, 0, rd); chk("t4_running", 32'(rd), 32'h0002);

        // STATUS write lands in the timeout clock: event wins
        n = 0;
        while (!(m_run[1] && m_cnt[1] == 0) && n < 50) begin @(posedge clk); #1; n++; end
        chk("t5_sync", 32'(n < 50), 32'd1);
        bus_write(1, 0, 16'h0);
        bus_read(1, 0, rd); chk("t5_to_kept", 32'(rd), 32'h0003);
        bus_write(1, 1, 16'hC);
        bus_read(1, 0, rd); chk("t5_stop_wins", 32'(rd), 32'h0001);
        chk("t5_irq1_off", 32'(irq[1]), 32'd0);

        // asynchronous reset mid-count
        bus_read(0, 2, rd);
        chk("t6_irq2_high", 32'(irq[2]), 32'd1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("t6_async_irq", 32'(irq), 32'd0);
        chk("t6_async_rd", 32'(bus.readdata), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        bus_read(1, 2, rd); chk("t6_periodl", 32'(rd), 32'h869F);
        bus_read(1, 3, rd); chk("t6_periodh", 32'(rd), 32'h0001);

        // random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            int r, ch, o;
            logic [15:0] d;
            r  = $urandom_range(0, 9);
            ch = $urandom_range(0, NCH - 1);
            o  = $urandom_range(0, 7);
            if (r < 4) begin
                @(posedge clk); #1;
            end else if (r < 7) begin
                bus_read(ch, o, rd);
            end else begin
                case (o)
                    1: d = 16'($urandom_range(0, 15));
                    2: d = 16'($urandom_range(0, 12));
                    3: d = ($urandom_range(0, 7) == 0) ? 16'd1 : 16'd0;
                    default: d = 16'($urandom);
                endcase
                bus_write(ch, o, d);
            end
        end

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
